// File: rtl/sram_1p_bm_mbist.sv
// Single-port SRAM model with bit-mask writes and an on-chip March C- MBIST engine.
// Optional build macro SRAM_STUCK_AT_EN forces bit FI_BIT of word FI_ADDR to read as 0.
module sram_1p_bm_mbist #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 1024,
    parameter int AW      = $clog2(DEPTH),
    parameter int FI_ADDR = 0,
    parameter int FI_BIT  = 0
) (
    input  logic             A_CLK,
    input  logic             A_RST_N,
    input  logic             A_MEN,
    input  logic             A_WEN,
    input  logic             A_REN,
    input  logic [AW-1:0]    A_ADDR,
    input  logic [WIDTH-1:0] A_DIN,
    input  logic [WIDTH-1:0] A_BM,
    output logic [WIDTH-1:0] A_DOUT,
    input  logic             A_BIST_START,
    output logic             A_BIST_BUSY,
    output logic             A_BIST_DONE,
    output logic             A_BIST_FAIL,
    output logic [AW-1:0]    A_BIST_FAIL_ADDR
);

`ifdef SRAM_STUCK_AT_EN
    localparam bit FI_EN = 1'b1;
`else
    localparam bit FI_EN = 1'b0;
`endif

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_CHK, S_DONE
    } state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    state_t           r_state;
    logic [AW-1:0]    r_addr;
    logic             r_ph;
    logic [WIDTH-1:0] r_dout;
    logic             r_fail;
    logic [AW-1:0]    r_fail_addr;
    logic             r_cmp_vld;
    logic [WIDTH-1:0] r_cmp_exp;
    logic [AW-1:0]    r_cmp_addr;

    state_t           w_state_nxt;
    logic [AW-1:0]    w_addr_nxt;
    logic             w_ph_nxt;
    logic             w_bwe;
    logic             w_bre;
    logic             w_bval;
    logic             w_start_acc;
    logic             w_down;
    logic             w_ones;
    logic             w_end;
    logic             w_busy;
    logic             w_fwr;
    logic             w_frd;

    // Every read path goes through here so an injected fault is seen by both BIST and users.
    function automatic logic [WIDTH-1:0] f_rd(input logic [AW-1:0] a);
        logic [WIDTH-1:0] d;
        if (int'(a) >= DEPTH) begin
            d = '0;
        end else begin
            d = r_mem[a];
            if (FI_EN && (a == AW'(FI_ADDR))) d[FI_BIT] = 1'b0;
        end
        return d;
    endfunction

    assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_fwr  = !w_busy && A_MEN && A_WEN && (int'(A_ADDR) < DEPTH);
    assign w_frd  = !w_busy && A_MEN && A_REN && !A_WEN;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_ph_nxt    = r_ph;
        w_bwe       = 1'b0;
        w_bre       = 1'b0;
        w_bval      = 1'b0;
        w_start_acc = 1'b0;
        w_down      = (r_state == S_M3) || (r_state == S_M4);
        w_ones      = (r_state == S_M2) || (r_state == S_M4);
        w_end       = (r_addr == (w_down ? '0 : LAST));
        case (r_state)
            S_IDLE, S_DONE: begin
                if (A_BIST_START) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_M0;
                    w_addr_nxt  = '0;
                    w_ph_nxt    = 1'b0;
                end
            end
            S_M0, S_M5: begin
                w_bwe = (r_state == S_M0);
                w_bre = (r_state == S_M5);
                if (w_end) begin
                    w_state_nxt = state_t'(r_state + 4'd1);
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt  = r_addr + AW'(1);
                end
            end
            // Read phase then write phase per address; the write phase advances the address.
            S_M1, S_M2, S_M3, S_M4: begin
                w_ph_nxt = ~r_ph;
                if (!r_ph) begin
                    w_bre  = 1'b1;
                    w_bval = w_ones;
                end else begin
                    w_bwe  = 1'b1;
                    w_bval = ~w_ones;
                    if (w_end) begin
                        w_state_nxt = state_t'(r_state + 4'd1);
                        w_addr_nxt  = ((r_state == S_M2) || (r_state == S_M3)) ? LAST : '0;
                    end else begin
                        w_addr_nxt  = w_down ? r_addr - AW'(1) : r_addr + AW'(1);
                    end
                end
            end
            S_CHK:   w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge A_CLK or negedge A_RST_N) begin
        if (!A_RST_N) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_ph        <= 1'b0;
            r_dout      <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_cmp_vld   <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_addr  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_ph       <= w_ph_nxt;
            r_cmp_vld  <= w_bre;
            r_cmp_exp  <= {WIDTH{w_bval}};
            r_cmp_addr <= r_addr;
            if (w_start_acc) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
            end else if (r_cmp_vld && (r_dout != r_cmp_exp) && !r_fail) begin
                r_fail      <= 1'b1;
                r_fail_addr <= r_cmp_addr;
            end
            if (w_bre) begin
                r_dout <= f_rd(r_addr);
            end else if (w_frd) begin
                r_dout <= f_rd(A_ADDR);
            end
        end
    end

    always_ff @(posedge A_CLK) begin
        if (w_bwe) begin
            r_mem[r_addr] <= {WIDTH{w_bval}};
        end else if (w_fwr) begin
            r_mem[A_ADDR] <= (r_mem[A_ADDR] & ~A_BM) | (A_DIN & A_BM);
        end
    end

    assign A_DOUT           = r_dout;
    assign A_BIST_BUSY      = w_busy;
    assign A_BIST_DONE      = (r_state == S_DONE);
    assign A_BIST_FAIL      = r_fail;
    assign A_BIST_FAIL_ADDR = r_fail_addr;

endmodule

// File: tb/tb_sram_1p_bm_mbist.sv
// Bench for sram_1p_bm_mbist: masked writes, reads, out-of-range access and March C- runs.
// A second instance with DEPTH=12 covers addresses beyond DEPTH and a non power-of-two run.
module tb_sram_1p_bm_mbist;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int DS = 12;
    localparam int AW = 4;
    localparam int FA = 6;
    localparam int FB = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          men, wen, ren, start;
    logic [AW-1:0] addr;
    logic [W-1:0]  din, bm;
    logic [W-1:0]  dout, s_dout;
    logic          busy, done, fail, s_busy, s_done, s_fail;
    logic [AW-1:0] fail_addr, s_fail_addr;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_mem [D];
    logic [W-1:0] m_dout;

    always #5 clk = ~clk;

    sram_1p_bm_mbist #(.WIDTH(W), .DEPTH(D), .FI_ADDR(FA), .FI_BIT(FB)) u_dut (
        .A_CLK(clk), .A_RST_N(rst_n), .A_MEN(men), .A_WEN(wen), .A_REN(ren),
        .A_ADDR(addr), .A_DIN(din), .A_BM(bm), .A_DOUT(dout),
        .A_BIST_START(start), .A_BIST_BUSY(busy), .A_BIST_DONE(done),
        .A_BIST_FAIL(fail), .A_BIST_FAIL_ADDR(fail_addr)
    );

    sram_1p_bm_mbist #(.WIDTH(W), .DEPTH(DS), .FI_ADDR(FA), .FI_BIT(FB)) u_small (
        .A_CLK(clk), .A_RST_N(rst_n), .A_MEN(men), .A_WEN(wen), .A_REN(ren),
        .A_ADDR(addr), .A_DIN(din), .A_BM(bm), .A_DOUT(s_dout),
        .A_BIST_START(start), .A_BIST_BUSY(s_busy), .A_BIST_DONE(s_done),
        .A_BIST_FAIL(s_fail), .A_BIST_FAIL_ADDR(s_fail_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] m_read(input int a);
        logic [W-1:0] v;
        if (a >= D) return '0;
        v = m_mem[a];
`ifdef SRAM_STUCK_AT_EN
        if (a == FA) v[FB] = 1'b0;
`endif
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string tag, input logic e, input logic w, input logic r,
                      input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
        men = e; wen = w; ren = r; addr = a; din = d; bm = m;
        step();
        if (e && w) m_mem[a] = (m_mem[a] & ~m) | (d & m);
        else if (e && r) m_dout = m_read(int'(a));
        men = 1'b0; wen = 1'b0; ren = 1'b0;
        chk(tag, dout, m_dout);
    endtask

    // March C- applied to the model array: element list of direction / read value / write value.
    task automatic march_model(output logic f, output int fa, output int cyc);
        int dir [6] = '{0, 0, 0, 1, 1, 0};
        int rd  [6] = '{-1, 0, 1, 0, 1, 0};
        int wr  [6] = '{0, 1, 0, 1, 0, -1};
        int a;
        f = 1'b0; fa = 0; cyc = 0;
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < D; j++) begin
                a = (dir[e] == 1) ? D - 1 - j : j;
                if (rd[e] >= 0) begin
                    cyc++;
                    if (!f && (m_read(a) != ((rd[e] == 1) ? 8'hFF : 8'h00))) begin
                        f = 1'b1;
                        fa = a;
                    end
                end
                if (wr[e] >= 0) begin
                    cyc++;
                    m_mem[a] = (wr[e] == 1) ? 8'hFF : 8'h00;
                end
            end
        end
        cyc++;
    endtask

    task automatic run_bist(input int mode, output int n);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_fail_clr", fail, 0);
        chk("start_faddr_clr", fail_addr, 0);
        while (done !== 1'b1 && n < 400) begin
            if (mode == 1 && n == 20) begin
                men = 1'b1; wen = 1'b1; addr = 4'd2; din = 8'hFF; bm = 8'hFF; start = 1'b1;
            end
            step();
            n++;
            if (mode == 1 && n == 21) begin
                men = 1'b0; wen = 1'b0; start = 1'b0;
            end
            if (mode == 2 && n == 40) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_fail", fail, 0);
                chk("abort_dout", dout, 0);
                step();
                rst_n = 1'b1;
                return;
            end
        end
        chk("bist_no_timeout", (n < 400), 1);
    endtask

    task automatic check_run(input string tag, input int n);
        logic f_exp;
        int   fa_exp, cyc_exp;
        march_model(f_exp, fa_exp, cyc_exp);
        m_dout = m_read(D - 1);
        chk({tag, "_latency"}, n, cyc_exp);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fail"}, fail, f_exp);
        chk({tag, "_faddr"}, fail_addr, fa_exp);
        chk({tag, "_small_done"}, s_done, 1);
        chk({tag, "_small_fail"}, s_fail, f_exp);
        chk({tag, "_small_faddr"}, s_fail_addr, fa_exp);
    endtask

    initial begin
        int n;
        int k;
        rst_n = 1'b0; men = 1'b0; wen = 1'b0; ren = 1'b0; start = 1'b0;
        addr = '0; din = '0; bm = '0; m_dout = '0;
        repeat (3) step();
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_faddr", fail_addr, 0);
        chk("rst_small_busy", s_busy, 0);
        rst_n = 1'b1;
        step();

        for (int a = 0; a < D; a++) op("init", 1'b1, 1'b1, 1'b0, AW'(a), 8'($urandom), 8'hFF);

        op("t1_wr_a5", 1'b1, 1'b1, 1'b0, 4'd3, 8'hA5, 8'hFF);
        op("t1_wr_mask", 1'b1, 1'b1, 1'b0, 4'd3, 8'h00, 8'h0F);
        op("t1_rd", 1'b1, 1'b0, 1'b1, 4'd3, 8'h00, 8'h00);
        chk("t1_a0", dout, 8'hA0);

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 3);
            op("rand", (k != 3), (k == 0 || k == 2) ? 1'b1 : ((k == 3) ? 1'($urandom) : 1'b0),
               (k == 1 || k == 2) ? 1'b1 : ((k == 3) ? 1'($urandom) : 1'b0),
               4'($urandom), 8'($urandom), 8'($urandom));
        end

        op("t2_pre_rd", 1'b1, 1'b0, 1'b1, 4'd7, 8'h00, 8'h00);
        op("t2_wr_rd_hold", 1'b1, 1'b1, 1'b1, 4'd5, 8'hC3, 8'hFF);
        op("t2_rd5", 1'b1, 1'b0, 1'b1, 4'd5, 8'h00, 8'h00);
        chk("t2_c3", dout, 8'hC3);
        op("t2_wr13", 1'b1, 1'b1, 1'b0, 4'd13, 8'h5A, 8'hFF);
        op("t2_rd13", 1'b1, 1'b0, 1'b1, 4'd13, 8'h00, 8'h00);
        chk("t2_small_oor", s_dout, 8'h00);

        run_bist(0, n);
        check_run("t3", n);
        op("t3_rd9", 1'b1, 1'b0, 1'b1, 4'd9, 8'h00, 8'h00);
        op("t3_rd6", 1'b1, 1'b0, 1'b1, 4'd6, 8'h00, 8'h00);

        run_bist(1, n);
        check_run("t5", n);
        op("t5_rd2", 1'b1, 1'b0, 1'b1, 4'd2, 8'h00, 8'h00);

        run_bist(2, n);
        m_dout = '0;
        run_bist(0, n);
        check_run("t6", n);

        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(0, 1);
            op("post", 1'b1, (k == 0), (k == 1), 4'($urandom), 8'($urandom), 8'($urandom));
        end
        op("post_rd6", 1'b1, 1'b0, 1'b1, 4'd6, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
